// File: rtl/serialiser.sv
`default_nettype none
// ============================================================================
// Module   : serialiser
// Purpose  : Byte-to-bit serialiser for the tag Tx path. Accepts frame bytes
//            from the response logic and emits one bit per accepted request,
//            LSB or MSB first, with support for a partial final byte and
//            bubble-free streaming across byte boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module serialiser #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic [2:0] in_bits,
  output logic       in_ready,
  output logic       out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_req,
  output logic       underrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t     state_q,    state_d;
  logic [7:0] shift_q,    shift_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic       is_last_q,  is_last_d;
  logic       underrun_q, underrun_d;

  logic       ready_int;
  logic       load;
  logic [2:0] load_cnt;
  logic [7:0] shifted;

  // Bits remaining minus one for a freshly loaded byte; in_bits==0 means a
  // full byte, and in_bits only matters on the frame's last byte.
  always_comb begin
    load_cnt = 3'd7;
    if (in_last && (in_bits != 3'd0)) begin
      load_cnt = 3'(in_bits - 3'd1);
    end
  end

  // Shift the byte toward whichever end feeds out_data.
  always_comb begin
    shifted = (LSB_FIRST != 0) ? {1'b0, shift_q[7:1]} : {shift_q[6:0], 1'b0};
  end

  // Next-state and output decode for the byte/bit handshake FSM.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    is_last_d  = is_last_q;
    underrun_d = 1'b0;
    ready_int  = 1'b0;
    load       = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = 1'b0;

    case (state_q)
      IDLE: begin
        ready_int = 1'b1;
        load      = in_valid;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = (LSB_FIRST != 0) ? shift_q[0] : shift_q[7];
        out_last  = is_last_q && (bit_cnt_q == 3'd0);
        if (out_req) begin
          if (bit_cnt_q != 3'd0) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else if (is_last_q) begin
            state_d = IDLE;
          end else begin
            // Byte boundary inside a frame: take the next byte now so the
            // bit stream has no bubble, otherwise stall and flag it.
            ready_int = 1'b1;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_d    = WAIT;
              underrun_d = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        ready_int = 1'b1;
        load      = in_valid;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      shift_d   = in_data;
      bit_cnt_d = load_cnt;
      is_last_d = in_last;
      state_d   = SEND;
    end
  end

  // Hold off upstream while reset is asserted.
  always_comb begin
    in_ready = ready_int & ~rst;
  end

  assign underrun = underrun_q;

  // State and datapath registers; reset clears the frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      is_last_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      is_last_q  <= is_last_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
`default_nettype wire
